// File: rtl/lc3_exec_unit.sv
// ---------------------------------------------------------------------------
// lc3_exec_unit
//   Registered LC-3 execute stage. It sits between register-file read and
//   writeback. It accepts one operation per valid/ready handshake. It returns
//   a registered result and the matching one-hot {N,Z,P} condition code.
//   Single-cycle ops: ADD, AND, NOT, PASS, XOR, SHL and SHR (arithmetic).
//   MUL is an iterative shift-add over WIDTH cycles.
//
// Parameters
//   WIDTH   datapath width (>= 4)
//   IMM_W   immediate width, sign-extended to WIDTH
//   MUL_EN  1: iterative MUL present; 0: MUL returns 0 with latency 1
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready is combinational)
//   op, sr2mux          operation select; B = sr2mux ? SEXT(imm) : src_b
//   src_a, src_b, imm   operands
//   out_valid/out_ready result handshake
//   result, nzp         registered result and its condition code
// ---------------------------------------------------------------------------
module lc3_exec_unit #(
  parameter int WIDTH  = 16,
  parameter int IMM_W  = 5,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             sr2mux,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            r_state, w_state_next;
  logic [WIDTH-1:0]  r_result, r_mcand, r_mpr, r_acc;
  logic [2:0]        r_nzp;
  logic              r_out_valid;
  logic [SH_W-1:0]   r_cnt;

  logic [WIDTH-1:0]  w_b, w_alu, w_acc_next;
  logic [SH_W-1:0]   w_shamt;
  logic              w_accept, w_is_mul, w_mul_start, w_fast, w_done;

  function automatic logic [2:0] f_nzp(input logic [WIDTH-1:0] v);
    f_nzp = {v[WIDTH-1], (v == '0), (!v[WIDTH-1] && (v != '0))};
  endfunction

  assign w_b     = sr2mux ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : src_b;
  assign w_shamt = w_b[SH_W-1:0];

  // A new op may enter only when idle and the output slot is free or draining.
  assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = (op == OP_MUL) && (MUL_EN != 0);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_fast      = w_accept && !w_is_mul;
  assign w_done      = (r_state == S_BUSY) && (r_cnt == SH_W'(WIDTH-1));

  // The low WIDTH bits of a shift-add product are the same for signed and
  // unsigned operands, so no sign handling is needed.
  assign w_acc_next  = r_mpr[0] ? (r_acc + r_mcand) : r_acc;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_alu = '0;
    case (op)
      OP_ADD:  w_alu = src_a + w_b;
      OP_AND:  w_alu = src_a & w_b;
      OP_NOT:  w_alu = ~w_b;
      OP_PASS: w_alu = src_a;
      OP_XOR:  w_alu = src_a ^ w_b;
      OP_SHL:  w_alu = src_a << w_shamt;
      OP_SHR:  w_alu = $signed(src_a) >>> w_shamt;
      default: w_alu = '0;  // MUL with the multiplier removed
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start) w_state_next = S_BUSY;
      S_BUSY:  if (w_done)      w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_nzp       <= 3'b010;
      r_out_valid <= 1'b0;
      r_mcand     <= '0;
      r_mpr       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_mul_start) begin
        r_mcand <= src_a;
        r_mpr   <= w_b;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_BUSY) begin
        r_acc   <= w_acc_next;
        r_mcand <= r_mcand << 1;
        r_mpr   <= r_mpr >> 1;
        r_cnt   <= r_cnt + SH_W'(1);
      end

      if (w_fast) begin
        r_result    <= w_alu;
        r_nzp       <= f_nzp(w_alu);
        r_out_valid <= 1'b1;
      end else if (w_done) begin
        r_result    <= w_acc_next;
        r_nzp       <= f_nzp(w_acc_next);
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign nzp       = r_nzp;

endmodule
